spi_slave_port: RTL and testbench
=================================

SPI_SLAVE_PORT -- requirements
Module: spi_slave_port

Interface
REQ-001 SHALL have parameter CPOL, default 0, idle level of sclk.
REQ-002 SHALL have parameter CPHA, default 0, 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-003 SHALL have port pro_clk, input, 1, the single clock for all logic.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port sclk, input, 1, SPI clock from the master, asynchronous to pro_clk.
REQ-006 SHALL have port ss_n, input, 1, active-low slave select, asynchronous.
REQ-007 SHALL have port mosi, input, 1, serial data from the master, asynchronous.
REQ-008 SHALL have port miso, output, 1, serial data to the master.
REQ-009 SHALL have port miso_oe, output, 1, miso drive enable; the pad drives Z when it is low.
REQ-010 SHALL have port tx_data, input, 8, word to transmit.
REQ-011 SHALL have port tx_load, input, 1, one-cycle strobe that captures tx_data.
REQ-012 SHALL have port tx_ready, output, 1, tx buffer empty and able to accept tx_load.
REQ-013 SHALL have port rx_data, output, 8, last complete received word.
REQ-014 SHALL have port rx_valid, output, 1, one-cycle pulse when rx_data updates.
REQ-015 SHALL have port underrun, output, 1, sticky: a word started with the tx buffer empty.
REQ-016 SHALL have port busy, output, 1, high while the state is ACTIVE.

Function
REQ-017 SHALL pass sclk, ss_n and mosi through 2-flop synchronizers on pro_clk; edges SHALL be detected from the synchronized sclk (current vs previous); pro_clk SHALL be at least 8x the sclk frequency.
REQ-018 Leading edge SHALL be rising when CPOL=0 and falling when CPOL=1; the sample edge SHALL be the leading edge if CPHA=0, otherwise the trailing edge; the shift edge SHALL be the other edge.
REQ-019 The FSM SHALL have the states IDLE and ACTIVE; IDLE->ACTIVE on a synchronized ss_n fall; ACTIVE->IDLE on a synchronized ss_n rise.
REQ-020 At each word start (ss_n fall, or 8-bit wrap while ss_n stays low), tx_shift SHALL load the tx buffer if it is full, otherwise 8'hFF with underrun set; the buffer SHALL become empty and the bit count SHALL be 0.
REQ-021 miso SHALL equal tx_shift[7] (MSB first); on each shift edge tx_shift SHALL shift left by 1, filling with 0.
REQ-022 When CPHA=1, the first leading edge of a word SHALL NOT shift, because the MSB is already presented.
REQ-023 On each sample edge, rx_shift SHALL take {rx_shift[6:0], mosi_sync} and the 3-bit bit count SHALL increment.
REQ-024 On the 8th sample edge, rx_data SHALL take the completed word and rx_valid SHALL pulse high for exactly one pro_clk cycle, 1 cycle after that sample edge is detected.
REQ-025 After the 8th bit with ss_n still low, the count SHALL wrap to 0 and the next word SHALL begin per REQ-020; back-to-back words SHALL have no gap.
REQ-026 If ss_n rises mid-word, the partial word SHALL be discarded, rx_valid SHALL NOT pulse, the count SHALL reset to 0 and the tx buffer SHALL keep its content.
REQ-027 miso_oe SHALL equal the inverse of synchronized ss_n; miso SHALL be 0 when miso_oe is low.
REQ-028 tx_load while tx_ready=1 SHALL capture tx_data and drive tx_ready low the next cycle.
REQ-029 tx_load while tx_ready=0 SHALL be ignored, including in the same cycle the buffer is consumed.
REQ-030 An accepted tx_load SHALL clear underrun.
REQ-031 Sclk edges while in IDLE SHALL be ignored.

Reset
REQ-032 While rst_n is low, the following SHALL hold asynchronously: state IDLE, all shift registers 0, count 0, rx_data 8'h00, rx_valid 0, tx_ready 1, underrun 0, busy 0, miso_oe 0, miso 0, and synchronizer flops set to idle levels (sclk = CPOL, ss_n = 1, mosi = 0).
REQ-033 Reset mid-transfer SHALL abort without an rx_valid pulse; after rst_n deasserts, the block SHALL wait for a fresh ss_n fall.

Structure
REQ-034 Package spi_pkg SHALL hold the SPI_WORD_W=8 constant, the FSM state enum (IDLE, ACTIVE) and the underrun fill value 8'hFF.
REQ-035 spi_slave_port SHALL instantiate sub-module spi_sync (a 2-flop synchronizer with a reset-value parameter) three times.

Verification
REQ-036 Mode 0, tx_load 8'hA5, master sends 8'h3C -> miso carries A5 MSB-first, rx_data=8'h3C, one rx_valid pulse, underrun=0.
REQ-037 Mode 3 (CPOL=1, CPHA=1), two back-to-back words 8'h81, 8'h7E under one ss_n low, tx reloaded between words -> two rx_valid pulses with 81 then 7E, no gap.
REQ-038 No tx_load, master sends 8'h55 -> miso shifts 8'hFF, underrun=1; a later tx_load clears underrun.
REQ-039 ss_n rises after 5 bits -> no rx_valid, busy falls, miso_oe=0; the next full word 8'hC3 is received correctly.
REQ-040 rst_n asserted at bit 4, then released -> all outputs at reset values, tx_ready=1, and the next full transfer succeeds.
REQ-041 tx_load issued twice with tx_ready=0 (8'h11 then 8'h22) -> only 8'h11 is transmitted.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI slave port.
package spi_pkg;

  localparam int SPI_WORD_W = 8;
  localparam int CNT_W      = $clog2(SPI_WORD_W);

  // Shifted out when a word starts with nothing loaded.
  localparam logic [SPI_WORD_W-1:0] UNDERRUN_FILL = 8'hFF;

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_e;

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchronizer with a configurable reset (idle) level.
module spi_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // NOTE: non-blocking (<=) makes both flops sample pre-edge values; blocking would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/spi_slave_port.sv
// SPI slave, all four modes, oversampled on pro_clk; one-word tx buffer.
module spi_slave_port
  import spi_pkg::*;
#(
  parameter logic CPOL = 1'b0,
  parameter logic CPHA = 1'b0
) (
  input  logic                  pro_clk,
  input  logic                  rst_n,
  input  logic                  sclk,
  input  logic                  ss_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [SPI_WORD_W-1:0] tx_data,
  input  logic                  tx_load,
  output logic                  tx_ready,
  output logic [SPI_WORD_W-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  underrun,
  output logic                  busy
);

  logic sclk_s, ss_n_s, mosi_s;

  spi_sync #(.RST_VAL(CPOL)) u_sync_sclk (.clk(pro_clk), .rst_n(rst_n), .d_i(sclk), .q_o(sclk_s));
  spi_sync #(.RST_VAL(1'b1)) u_sync_ss   (.clk(pro_clk), .rst_n(rst_n), .d_i(ss_n), .q_o(ss_n_s));
  spi_sync #(.RST_VAL(1'b0)) u_sync_mosi (.clk(pro_clk), .rst_n(rst_n), .d_i(mosi), .q_o(mosi_s));

  state_e                  state_q, state_d;
  logic                    sclk_prev_q, ss_prev_q;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [SPI_WORD_W-1:0]   tx_shift_q, tx_shift_d;
  logic [SPI_WORD_W-1:0]   tx_buf_q, tx_buf_d;
  logic                    tx_full_q, tx_full_d;
  logic [SPI_WORD_W-2:0]   rx_shift_q, rx_shift_d;  // the 8th bit comes straight from mosi_s
  logic [SPI_WORD_W-1:0]   rx_data_q, rx_data_d;
  logic                    rx_valid_q, rx_valid_d;
  logic                    underrun_q, underrun_d;
  logic                    pend_q, pend_d;          // word wrapped; reload on the next shift edge
  logic                    skip_q, skip_d;          // CPHA=1: first leading edge keeps the MSB
  logic                    fill_q, fill_d;          // current word is filler; flag once clocked
  logic                    load_word;

  logic sclk_rise, sclk_fall, lead_edge, trail_edge, sample_edge, shift_edge;
  logic ss_fall, ss_rise, tx_accept;

  assign sclk_rise   = sclk_s & ~sclk_prev_q;
  assign sclk_fall   = ~sclk_s & sclk_prev_q;
  assign lead_edge   = CPOL ? sclk_fall : sclk_rise;
  assign trail_edge  = CPOL ? sclk_rise : sclk_fall;
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;
  assign ss_fall     = ss_prev_q & ~ss_n_s;
  assign ss_rise     = ~ss_prev_q & ss_n_s;
  assign tx_accept   = tx_load & ~tx_full_q;

  // NOTE: every _d gets its hold value first, so no branch can leave a latch behind.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tx_shift_d = tx_shift_q;
    tx_buf_d   = tx_buf_q;
    tx_full_d  = tx_full_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    underrun_d = underrun_q;
    pend_d     = pend_q;
    skip_d     = skip_q;
    fill_d     = fill_q;
    load_word  = 1'b0;

    case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d   = ACTIVE;
          load_word = 1'b1;
          cnt_d     = '0;
          pend_d    = 1'b0;
          skip_d    = CPHA;
        end
      end
      ACTIVE: begin
        if (ss_rise) begin
          state_d = IDLE;
          cnt_d   = '0;
          pend_d  = 1'b0;
          skip_d  = 1'b0;
          fill_d  = 1'b0;
        end else begin
          if (sample_edge) begin
            rx_shift_d = {rx_shift_q[SPI_WORD_W-3:0], mosi_s};
            cnt_d      = cnt_q + 1'b1;
            if (fill_q) begin
              underrun_d = 1'b1;
              fill_d     = 1'b0;
            end
            if (cnt_q == CNT_W'(SPI_WORD_W - 1)) begin
              rx_data_d  = {rx_shift_q, mosi_s};
              rx_valid_d = 1'b1;
              pend_d     = 1'b1;
            end
          end
          if (shift_edge) begin
            if (pend_q) begin
              load_word = 1'b1;
              pend_d    = 1'b0;
            end else if (skip_q) begin
              skip_d = 1'b0;
            end else begin
              tx_shift_d = {tx_shift_q[SPI_WORD_W-2:0], 1'b0};
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load_word) begin
      if (tx_full_q) begin
        tx_shift_d = tx_buf_q;
        tx_full_d  = 1'b0;
      end else begin
        tx_shift_d = UNDERRUN_FILL;
        fill_d     = 1'b1;
      end
    end

    // Requires an empty buffer, so it can never collide with the consume above.
    if (tx_accept) begin
      tx_buf_d   = tx_data;
      tx_full_d  = 1'b1;
      underrun_d = 1'b0;
    end
  end

  always_ff @(posedge pro_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sclk_prev_q <= CPOL;
      ss_prev_q   <= 1'b1;
      cnt_q       <= '0;
      tx_shift_q  <= '0;
      tx_buf_q    <= '0;
      tx_full_q   <= 1'b0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      pend_q      <= 1'b0;
      skip_q      <= 1'b0;
      fill_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_prev_q <= sclk_s;
      ss_prev_q   <= ss_n_s;
      cnt_q       <= cnt_d;
      tx_shift_q  <= tx_shift_d;
      tx_buf_q    <= tx_buf_d;
      tx_full_q   <= tx_full_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      underrun_q  <= underrun_d;
      pend_q      <= pend_d;
      skip_q      <= skip_d;
      fill_q      <= fill_d;
    end
  end

  assign miso_oe  = ~ss_n_s;
  assign miso     = miso_oe & tx_shift_q[SPI_WORD_W-1];
  assign tx_ready = ~tx_full_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign underrun = underrun_q;
  assign busy     = (state_q == ACTIVE);

endmodule

// File: tb/tb_spi_slave_port.sv
// Directed bench: a mode-0 and a mode-3 slave driven by a behavioural SPI master.
module tb_spi_slave_port;

  localparam int H = 8;  // pro_clk cycles per sclk half period

  logic       pro_clk = 1'b0;
  logic       rst_n;
  logic       sclk, mosi, ss0_n, ss3_n;
  logic [7:0] tx_data;
  logic       tx_load0, tx_load3;

  logic       miso0, miso_oe0, tx_ready0, rx_valid0, underrun0, busy0;
  logic       miso3, miso_oe3, tx_ready3, rx_valid3, underrun3, busy3;
  logic [7:0] rx_data0, rx_data3;

  always #5 pro_clk = ~pro_clk;

  spi_slave_port #(.CPOL(1'b0), .CPHA(1'b0)) u_dut0 (
    .pro_clk(pro_clk), .rst_n(rst_n), .sclk(sclk), .ss_n(ss0_n), .mosi(mosi),
    .miso(miso0), .miso_oe(miso_oe0), .tx_data(tx_data), .tx_load(tx_load0),
    .tx_ready(tx_ready0), .rx_data(rx_data0), .rx_valid(rx_valid0),
    .underrun(underrun0), .busy(busy0)
  );

  spi_slave_port #(.CPOL(1'b1), .CPHA(1'b1)) u_dut3 (
    .pro_clk(pro_clk), .rst_n(rst_n), .sclk(sclk), .ss_n(ss3_n), .mosi(mosi),
    .miso(miso3), .miso_oe(miso_oe3), .tx_data(tx_data), .tx_load(tx_load3),
    .tx_ready(tx_ready3), .rx_data(rx_data3), .rx_valid(rx_valid3),
    .underrun(underrun3), .busy(busy3)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Every rx_valid high cycle is logged, so a stretched pulse shows up as an extra entry.
  logic [7:0] rxq0[$];
  logic [7:0] rxq3[$];
  always @(negedge pro_clk) begin
    if (rx_valid0) rxq0.push_back(rx_data0);
    if (rx_valid3) rxq3.push_back(rx_data3);
  end

  bit use3, cpol, cpha;

  function automatic logic cur_miso();
    return use3 ? miso3 : miso0;
  endfunction

  // {miso, miso_oe, tx_ready, rx_valid, underrun, busy}
  function automatic logic [5:0] st0();
    return {miso0, miso_oe0, tx_ready0, rx_valid0, underrun0, busy0};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge pro_clk);
  endtask

  task automatic set_ss(input logic v);
    if (use3) ss3_n = v;
    else      ss0_n = v;
    tick(H);
  endtask

  task automatic load_tx(input logic [7:0] d);
    tx_data = d;
    if (use3) tx_load3 = 1'b1;
    else      tx_load0 = 1'b1;
    tick(1);
    tx_load0 = 1'b0;
    tx_load3 = 1'b0;
  endtask

  // Master: drives mosi MSB first on its shift edge, captures miso on its sample edge.
  task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    mi = '0;
    for (int k = 0; k < nbits; k++) begin
      if (!cpha) begin
        mosi = mo[7-k];
        tick(H);
        sclk = ~cpol;
        mi[7-k] = cur_miso();
        tick(H);
        sclk = cpol;
      end else begin
        sclk = ~cpol;
        mosi = mo[7-k];
        tick(H);
        sclk = cpol;
        mi[7-k] = cur_miso();
        tick(H);
      end
    end
    if (!cpha) tick(H);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  logic [7:0] mi, mi2;

  initial begin
    rst_n = 1'b0; sclk = 1'b0; mosi = 1'b0; ss0_n = 1'b1; ss3_n = 1'b1;
    tx_data = '0; tx_load0 = 1'b0; tx_load3 = 1'b0;
    use3 = 1'b0; cpol = 1'b0; cpha = 1'b0;
    tick(3);
    check("reset_status0", 32'(st0()), 32'h08);
    check("reset_rx_data0", 32'(rx_data0), 32'h00);
    check("reset_tx_ready3", 32'(tx_ready3), 32'h1);
    rst_n = 1'b1;
    tick(4);

    // Mode 0 basic transfer.
    rxq0.delete();
    load_tx(8'hA5);
    check("m0_tx_ready_after_load", 32'(tx_ready0), 32'h0);
    set_ss(1'b0);
    check("m0_busy", 32'(busy0), 32'h1);
    check("m0_miso_oe", 32'(miso_oe0), 32'h1);
    check("m0_buffer_consumed", 32'(tx_ready0), 32'h1);
    xfer(8'h3C, 8, mi);
    check("m0_miso_word", 32'(mi), 32'hA5);
    check("m0_rx_count", 32'(rxq0.size()), 32'd1);
    check("m0_rx_word", 32'(rxq0[0]), 32'h3C);
    set_ss(1'b1);
    check("m0_end_status", 32'(st0()), 32'h08);

    // Underrun, then cleared by a load; a second load while full is dropped.
    rxq0.delete();
    set_ss(1'b0);
    xfer(8'h55, 8, mi);
    check("ur_miso_fill", 32'(mi), 32'hFF);
    check("ur_rx_word", 32'(rxq0[0]), 32'h55);
    set_ss(1'b1);
    check("ur_flag_set", 32'(underrun0), 32'h1);
    load_tx(8'h11);
    check("ur_flag_cleared", 32'(underrun0), 32'h0);
    load_tx(8'h22);
    check("dbl_tx_ready", 32'(tx_ready0), 32'h0);
    rxq0.delete();
    set_ss(1'b0);
    xfer(8'h96, 8, mi);
    set_ss(1'b1);
    check("dbl_only_first_sent", 32'(mi), 32'h11);
    check("dbl_rx_word", 32'(rxq0[0]), 32'h96);

    // ss_n rises after 5 bits: partial discarded, reloaded buffer survives.
    rxq0.delete();
    load_tx(8'h5A);
    set_ss(1'b0);
    load_tx(8'hC9);
    xfer(8'hF0, 5, mi);
    check("abort_partial_miso", 32'(mi), 32'h58);
    set_ss(1'b1);
    check("abort_no_rx_valid", 32'(rxq0.size()), 32'd0);
    check("abort_status", 32'(st0()), 32'h00);
    set_ss(1'b0);
    xfer(8'hC3, 8, mi);
    set_ss(1'b1);
    check("abort_next_miso", 32'(mi), 32'hC9);
    check("abort_next_rx_count", 32'(rxq0.size()), 32'd1);
    check("abort_next_rx_word", 32'(rxq0[0]), 32'hC3);

    // Reset at bit 4 with the buffer full.
    rxq0.delete();
    load_tx(8'h3E);
    set_ss(1'b0);
    load_tx(8'h77);
    xfer(8'hA0, 4, mi);
    rst_n = 1'b0;
    ss0_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
    tick(2);
    check("rst_mid_status", 32'(st0()), 32'h08);
    check("rst_mid_rx_data", 32'(rx_data0), 32'h00);
    rst_n = 1'b1;
    tick(4);
    check("rst_after_status", 32'(st0()), 32'h08);
    check("rst_no_rx_valid", 32'(rxq0.size()), 32'd0);
    load_tx(8'h69);
    set_ss(1'b0);
    xfer(8'h4B, 8, mi);
    set_ss(1'b1);
    check("rst_next_miso", 32'(mi), 32'h69);
    check("rst_next_rx_word", 32'(rxq0[0]), 32'h4B);

    // The mode-3 slave saw all of that sclk activity with ss3_n high.
    check("idle_edges_ignored", 32'(rxq3.size()), 32'd0);
    check("idle_busy3", 32'(busy3), 32'h0);

    // Mode 3, two back-to-back words under one ss_n low.
    use3 = 1'b1; cpol = 1'b1; cpha = 1'b1;
    sclk = 1'b1;
    tick(H);
    rxq3.delete();
    load_tx(8'h5A);
    set_ss(1'b0);
    check("m3_busy", 32'(busy3), 32'h1);
    check("m3_miso_oe", 32'(miso_oe3), 32'h1);
    load_tx(8'hC6);
    check("m3_reload_accepted", 32'(tx_ready3), 32'h0);
    xfer(8'h81, 8, mi);
    xfer(8'h7E, 8, mi2);
    set_ss(1'b1);
    check("m3_miso_word1", 32'(mi), 32'h5A);
    check("m3_miso_word2", 32'(mi2), 32'hC6);
    check("m3_rx_count", 32'(rxq3.size()), 32'd2);
    check("m3_rx_word1", 32'(rxq3[0]), 32'h81);
    check("m3_rx_word2", 32'(rxq3[1]), 32'h7E);
    check("m3_underrun", 32'(underrun3), 32'h0);
    check("m3_end_busy", 32'(busy3), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
